// File: rtl/bus_pkg.sv
// Shared types and defaults for the bus master port: FSM encoding,
// default bus widths and the grant-wait / transfer counter widths.
package bus_pkg;

   localparam int DEF_ADDR_WIDTH = 16;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int TMO_WIDTH      = 8;   // holds GNT_TIMEOUT up to 255
   localparam int CNT_WIDTH      = 4;   // holds RD_CYCLES up to 15

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_XFER = 2'd2,
      ST_RESP = 2'd3
   } state_t;

endpackage

// File: rtl/bus_master_port.sv
// Single-request bus master port: takes one core request, arbitrates for the
// bus, performs a write or multi-cycle read, then returns a one-cycle response.
module bus_master_port
   import bus_pkg::*;
#(
   parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int RD_CYCLES   = 2,
   parameter int GNT_TIMEOUT = 255
) (
   input  logic                  clk,
   input  logic                  rstn,
   // Core side: a request is taken on a rising edge where req_valid and req_ready are both 1.
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_wr,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   // Arbiter and bus side
   output logic                  breq,
   input  logic                  bgrant,
   output logic [ADDR_WIDTH-1:0] m_addr,
   output logic [DATA_WIDTH-1:0] m_wdata,
   output logic                  m_wen,
   output logic                  m_ren,
   input  logic [DATA_WIDTH-1:0] m_rdata,
   // Current FSM state, for observation only
   output state_t                o_dbg_state
);

   localparam logic [CNT_WIDTH-1:0] RD_LAST  = CNT_WIDTH'(RD_CYCLES - 1);
   localparam logic [TMO_WIDTH-1:0] TMO_LAST = TMO_WIDTH'(GNT_TIMEOUT - 1);

   state_t                r_state;
   logic [TMO_WIDTH-1:0]  r_wait;
   logic [CNT_WIDTH-1:0]  r_cnt;
   logic                  r_wr;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic                  r_err;

   state_t                w_state_nxt;
   logic [TMO_WIDTH-1:0]  w_wait_nxt;
   logic [CNT_WIDTH-1:0]  w_cnt_nxt;
   logic                  w_accept;
   logic                  w_capture;
   logic                  w_timeout;
   logic                  w_xfer;

   always_comb begin
      w_state_nxt = r_state;
      w_wait_nxt  = r_wait;
      w_cnt_nxt   = r_cnt;
      w_accept    = 1'b0;
      w_capture   = 1'b0;
      w_timeout   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (req_valid) begin
               w_accept    = 1'b1;
               w_wait_nxt  = '0;
               w_state_nxt = ST_REQ;
            end
         end
         ST_REQ: begin
            if (bgrant) begin
               w_cnt_nxt   = '0;
               w_state_nxt = ST_XFER;
            end else if (r_wait == TMO_LAST) begin
               w_timeout   = 1'b1;
               w_state_nxt = ST_RESP;
            end else begin
               w_wait_nxt  = r_wait + 1'b1;
            end
         end
         ST_XFER: begin
            // Losing the grant mid-transfer restarts arbitration and the whole transfer.
            if (!bgrant) begin
               w_wait_nxt  = '0;
               w_cnt_nxt   = '0;
               w_state_nxt = ST_REQ;
            end else if (r_wr) begin
               w_state_nxt = ST_RESP;
            end else if (r_cnt == RD_LAST) begin
               w_capture   = 1'b1;
               w_state_nxt = ST_RESP;
            end else begin
               w_cnt_nxt   = r_cnt + 1'b1;
            end
         end
         ST_RESP: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= ST_IDLE;
         r_wait  <= '0;
         r_cnt   <= '0;
         r_wr    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_wait  <= w_wait_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_accept) begin
            r_wr    <= req_wr;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_rdata <= '0;
            r_err   <= 1'b0;
         end
         if (w_capture) r_rdata <= m_rdata;
         if (w_timeout) r_err   <= 1'b1;
      end
   end

   // Strobes are gated by bgrant directly so a dropped grant silences the bus in the same cycle.
   assign w_xfer      = (r_state == ST_XFER);
   assign m_addr      = w_xfer ? r_addr  : '0;
   assign m_wdata     = w_xfer ? r_wdata : '0;
   assign m_wen       = w_xfer & bgrant & r_wr;
   assign m_ren       = w_xfer & bgrant & ~r_wr;

   assign req_ready   = (r_state == ST_IDLE);
   assign breq        = (r_state == ST_REQ) | w_xfer;
   assign rsp_valid   = (r_state == ST_RESP);
   assign rsp_rdata   = rsp_valid ? r_rdata : '0;
   assign rsp_err     = rsp_valid & r_err;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_bus_master_port.sv
// Self-checking bench for bus_master_port: directed scenarios plus a short
// random run, with responses checked in order against an expected queue.
module tb_bus_master_port;
   import bus_pkg::*;

   localparam int AW = 16;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_wr = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [DW-1:0] req_wdata = '0;
   logic          rsp_valid;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;
   logic          breq;
   logic          bgrant = 1'b0;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic          m_wen;
   logic          m_ren;
   logic [DW-1:0] m_rdata;
   state_t        dbg_state;

   bus_master_port #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_CYCLES(2), .GNT_TIMEOUT(255)
   ) dut (
      .clk(clk), .rstn(rstn),
      .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .breq(breq), .bgrant(bgrant),
      .m_addr(m_addr), .m_wdata(m_wdata), .m_wen(m_wen), .m_ren(m_ren),
      .m_rdata(m_rdata), .o_dbg_state(dbg_state)
   );

   // ---------------- clock / cycle count ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   logic [DW:0]   exp_q[$];       // {err, rdata}
   logic [DW-1:0] bus_rdata = '0;
   logic          cur_wr = 1'b0;
   logic [AW-1:0] cur_addr = '0;
   logic [DW-1:0] cur_wdata = '0;
   int n_cmp = 0;
   int n_err = 0;
   int wen_cnt = 0, ren_cnt = 0, breq_cnt = 0, rsp_cnt = 0, last_rsp_cyc = 0;

   assign m_rdata = bus_rdata;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      logic [DW:0] e;
      if (rstn) begin
         if (dbg_state != ST_XFER)
            check("bus_idle_zero", {m_wen, m_ren, m_addr, m_wdata}, 64'd0);
         if (m_wen || m_ren) begin
            check("bus_granted", bgrant, 1);
            check("bus_dir", m_wen, cur_wr);
            check("bus_addr", m_addr, cur_addr);
            if (m_wen) check("bus_wdata", m_wdata, cur_wdata);
         end
         if (m_wen) wen_cnt++;
         if (m_ren) ren_cnt++;
         if (breq)  breq_cnt++;
         if (rsp_valid) begin
            rsp_cnt++;
            last_rsp_cyc = cyc;
            check("rsp_breq_low", breq, 0);
            check("rsp_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("rsp_err", rsp_err, e[DW]);
               check("rsp_rdata", rsp_rdata, e[DW-1:0]);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic push_exp(input logic wr, input logic err);
      logic [DW-1:0] d;
      d = (wr || err) ? '0 : bus_rdata;
      exp_q.push_back({err, d});
   endtask

   task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input logic do_push, input logic exp_err, output int t_acc);
      int n = 0;
      @(negedge clk);
      req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata;
      while (!req_ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("accept_in_time", n < 2000, 1);
      t_acc = cyc;
      cur_wr = wr; cur_addr = addr; cur_wdata = wdata;
      if (do_push) push_exp(wr, exp_err);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic wait_rsp(input int target, input int budget);
      int n = 0;
      while (rsp_cnt < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("rsp_in_time", rsp_cnt >= target, 1);
   endtask

   // ---------------- stimulus ----------------
   logic [AW-1:0] h_addr [3];
   logic [DW-1:0] h_data [3];
   logic          h_wr   [3];

   initial begin
      int t, t_hold[3], base, k, n, d;
      logic wr;
      logic [AW-1:0] a;
      logic [DW-1:0] wd;

      // Reset values before any clock edge
      #1;
      check("rst_req_ready", req_ready, 1);
      check("rst_breq", breq, 0);
      check("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 64'd0);
      check("rst_bus", {m_wen, m_ren, m_addr, m_wdata}, 64'd0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;

      // Read with grant held high
      bgrant = 1'b1; bus_rdata = 32'hDEAD_BEEF;
      base = ren_cnt;
      issue(1'b0, 16'h1004, '0, 1'b1, 1'b0, t);
      wait_rsp(rsp_cnt + 1, 50);
      check("rd_latency", last_rsp_cyc - t, 4);
      check("rd_ren_cycles", ren_cnt - base, 2);

      // Write with grant arriving after 5 waiting cycles
      bgrant = 1'b0;
      base = wen_cnt;
      issue(1'b1, 16'h2008, 32'h1234_5678, 1'b1, 1'b0, t);
      repeat (5) @(negedge clk);
      bgrant = 1'b1;
      wait_rsp(rsp_cnt + 1, 50);
      check("wr_latency", last_rsp_cyc - t, 8);
      check("wr_wen_cycles", wen_cnt - base, 1);

      // Grant never given: timeout after 255 request cycles
      bgrant = 1'b0;
      base = breq_cnt;
      issue(1'b0, 16'h3000, '0, 1'b1, 1'b1, t);
      wait_rsp(rsp_cnt + 1, 400);
      check("tmo_breq_cycles", breq_cnt - base, 255);
      check("tmo_latency", last_rsp_cyc - t, 256);
      @(negedge clk);
      check("tmo_breq_after", breq, 0);

      // Grant dropped in first transfer cycle, regranted 3 cycles later
      bgrant = 1'b1; bus_rdata = 32'hCAFE_0042;
      base = ren_cnt; k = rsp_cnt;
      issue(1'b0, 16'h4010, '0, 1'b1, 1'b0, t);
      @(posedge clk); #1;
      bgrant = 1'b0;
      #3;
      check("drop_ren_gated", m_ren, 0);
      repeat (3) @(posedge clk);
      #1 bgrant = 1'b1;
      wait_rsp(k + 1, 50);
      repeat (4) @(negedge clk);
      check("drop_latency", last_rsp_cyc - t, 8);
      check("drop_ren_cycles", ren_cnt - base, 2);
      check("drop_single_rsp", rsp_cnt - k, 1);

      // Reset during transfer abandons the read
      bus_rdata = 32'h5555_AAAA;
      k = rsp_cnt;
      issue(1'b0, 16'h5020, '0, 1'b0, 1'b0, t);
      @(posedge clk); #2;
      check("pre_rst_ren", m_ren, 1);
      rstn = 1'b0;
      #1;
      check("mid_rst_ready", req_ready, 1);
      check("mid_rst_breq", breq, 0);
      check("mid_rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 64'd0);
      check("mid_rst_bus", {m_wen, m_ren, m_addr, m_wdata}, 64'd0);
      @(negedge clk);
      rstn = 1'b1;
      repeat (6) @(negedge clk);
      check("rst_no_rsp", rsp_cnt - k, 0);
      issue(1'b1, 16'h0ABC, 32'h0BAD_F00D, 1'b1, 1'b0, t);
      wait_rsp(k + 1, 50);
      check("post_rst_wr_latency", last_rsp_cyc - t, 3);

      // req_valid held high across three requests
      bus_rdata = 32'h7777_1234;
      h_wr[0] = 1'b1; h_addr[0] = 16'h6000; h_data[0] = 32'hA0A0_0001;
      h_wr[1] = 1'b0; h_addr[1] = 16'h6004; h_data[1] = 32'hA0A0_0002;
      h_wr[2] = 1'b1; h_addr[2] = 16'h6008; h_data[2] = 32'hA0A0_0003;
      k = 0; n = 0; base = rsp_cnt;
      @(negedge clk);
      req_valid = 1'b1; req_wr = h_wr[0]; req_addr = h_addr[0]; req_wdata = h_data[0];
      while (k < 3 && n < 200) begin
         if (req_ready) begin
            t_hold[k] = cyc;
            cur_wr = h_wr[k]; cur_addr = h_addr[k]; cur_wdata = h_data[k];
            push_exp(h_wr[k], 1'b0);
            @(negedge clk);
            k++;
            if (k < 3) begin
               req_wr = h_wr[k]; req_addr = h_addr[k]; req_wdata = h_data[k];
            end
         end else begin
            @(negedge clk);
         end
         n++;
      end
      req_valid = 1'b0;
      check("hold_accepts", k, 3);
      wait_rsp(base + 3, 50);
      check("hold_gap_wr", t_hold[1] - t_hold[0], 4);
      check("hold_gap_rd", t_hold[2] - t_hold[1], 5);
      check("hold_rsp_count", rsp_cnt - base, 3);

      // Random requests with random grant delay
      for (int i = 0; i < 8; i++) begin
         wr = 1'($urandom_range(0, 1));
         a  = AW'($urandom_range(0, 16'hFFFF));
         wd = $urandom;
         bus_rdata = $urandom;
         d  = $urandom_range(0, 4);
         bgrant = 1'b0;
         k = rsp_cnt;
         issue(wr, a, wd, 1'b1, 1'b0, t);
         repeat (d) @(negedge clk);
         bgrant = 1'b1;
         wait_rsp(k + 1, 50);
         check("rand_latency", last_rsp_cyc - t, (wr ? 3 : 4) + d);
      end

      repeat (3) @(negedge clk);
      check("queue_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
